// File: rtl/datagen_run_ctrl.sv
// rtl/datagen_run_ctrl.sv - run sequencer for the test data generator chain
// Sequences chain reset, settle, triggered run and stream-buffer drain; reports status and counts.
module datagen_run_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int DRAIN_QUIET   = 32,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] runLengthCfg,
  input  logic [1:0]       dataRateCfg,
  input  logic [7:0]       trigIntervalCfg,
  input  logic             L1A,
  input  logic             streamBufAlmostFull,
  input  logic             noError,
  output logic             genReset_n,
  output logic             disTrig,
  output logic [1:0]       dataRate,
  output logic [7:0]       trigInterval,
  output logic             busy,
  output logic             done,
  output logic             timedOut,
  output logic             aborted,
  output logic [CNT_W-1:0] l1aCount,
  output logic [CNT_W-1:0] errCount,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // One phase counter serves RESET, SETTLE and DRAIN; size it for the longest.
  localparam int MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B = (MAX_A > DRAIN_TIMEOUT) ? MAX_A : DRAIN_TIMEOUT;
  localparam int PH_W  = $clog2(MAX_B + 1);
  localparam int Q_W   = $clog2(DRAIN_QUIET + 1);

  logic [2:0]       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [Q_W-1:0]   quiet_q, quiet_d;
  logic [CNT_W-1:0] l1a_q, l1a_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [1:0]       rate_q, rate_d;
  logic [7:0]       intv_q, intv_d;
  logic             gen_reset_n_q, gen_reset_n_d;
  logic             dis_trig_q, dis_trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;
  logic             aborted_q, aborted_d;

  logic [CNT_W-1:0] l1a_inc;
  logic [CNT_W-1:0] err_inc;
  logic             active;

  always_comb begin
    l1a_inc = (l1a_q == '1) ? l1a_q : l1a_q + 1'b1;
    err_inc = (err_q == '1) ? err_q : err_q + 1'b1;
    active  = (state_q == S_RUN) || (state_q == S_DRAIN);

    state_d     = state_q;
    phase_d     = phase_q + 1'b1;
    quiet_d     = '0;
    l1a_d       = l1a_q;
    err_d       = err_q;
    run_len_d   = run_len_q;
    rate_d      = rate_q;
    intv_d      = intv_q;
    timed_out_d = timed_out_q;
    aborted_d   = aborted_q;

    if (active && L1A) l1a_d = l1a_inc;
    if (active && !noError) err_d = err_inc;

    case (state_q)
      S_IDLE, S_DONE: begin
        phase_d = '0;
        if (start && !abort) begin
          state_d     = S_RESET;
          run_len_d   = runLengthCfg;
          rate_d      = dataRateCfg;
          intv_d      = trigIntervalCfg;
          l1a_d       = '0;
          err_d       = '0;
          timed_out_d = 1'b0;
          aborted_d   = 1'b0;
        end
      end
      S_RESET: begin
        if (abort) begin
          state_d   = S_DRAIN;
          aborted_d = 1'b1;
          phase_d   = '0;
        end else if (phase_q == PH_W'(RST_CYCLES - 1)) begin
          state_d = S_SETTLE;
          phase_d = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d   = S_DRAIN;
          aborted_d = 1'b1;
          phase_d   = '0;
        end else if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_RUN;
          phase_d = '0;
        end
      end
      S_RUN: begin
        phase_d = '0;
        if (abort) begin
          state_d   = S_DRAIN;
          aborted_d = 1'b1;
        end else if ((run_len_q != '0) && L1A && (l1a_inc == run_len_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        quiet_d = streamBufAlmostFull ? '0 : quiet_q + 1'b1;
        // Quiet exit is checked first so it wins over a coincident timeout.
        if (!streamBufAlmostFull && (quiet_q == Q_W'(DRAIN_QUIET - 1))) begin
          state_d = S_DONE;
          phase_d = '0;
        end else if (phase_q == PH_W'(DRAIN_TIMEOUT - 1)) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
          phase_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    gen_reset_n_d = (state_d == S_SETTLE) || (state_d == S_RUN) ||
                    (state_d == S_DRAIN)  || (state_d == S_DONE);
    dis_trig_d    = (state_d != S_RUN);
    busy_d        = (state_d == S_RESET) || (state_d == S_SETTLE) ||
                    (state_d == S_RUN)   || (state_d == S_DRAIN);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      quiet_q       <= '0;
      l1a_q         <= '0;
      err_q         <= '0;
      run_len_q     <= '0;
      rate_q        <= '0;
      intv_q        <= '0;
      gen_reset_n_q <= 1'b0;
      dis_trig_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      quiet_q       <= quiet_d;
      l1a_q         <= l1a_d;
      err_q         <= err_d;
      run_len_q     <= run_len_d;
      rate_q        <= rate_d;
      intv_q        <= intv_d;
      gen_reset_n_q <= gen_reset_n_d;
      dis_trig_q    <= dis_trig_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timed_out_q   <= timed_out_d;
      aborted_q     <= aborted_d;
    end
  end

  assign genReset_n   = gen_reset_n_q;
  assign disTrig      = dis_trig_q;
  assign dataRate     = rate_q;
  assign trigInterval = intv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timedOut     = timed_out_q;
  assign aborted      = aborted_q;
  assign l1aCount     = l1a_q;
  assign errCount     = err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_datagen_run_ctrl.sv
// tb/tb_datagen_run_ctrl.sv - directed self-checking bench for datagen_run_ctrl
module tb_datagen_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] runLengthCfg = '0;
  logic [1:0]  dataRateCfg = '0;
  logic [7:0]  trigIntervalCfg = '0;
  logic        L1A = 1'b0;
  logic        streamBufAlmostFull = 1'b0;
  logic        noError = 1'b1;
  logic        genReset_n, disTrig, busy, done, timedOut, aborted;
  logic [1:0]  dataRate;
  logic [7:0]  trigInterval;
  logic [15:0] l1aCount, errCount;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  datagen_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .runLengthCfg(runLengthCfg), .dataRateCfg(dataRateCfg), .trigIntervalCfg(trigIntervalCfg),
    .L1A(L1A), .streamBufAlmostFull(streamBufAlmostFull), .noError(noError),
    .genReset_n(genReset_n), .disTrig(disTrig), .dataRate(dataRate), .trigInterval(trigInterval),
    .busy(busy), .done(done), .timedOut(timedOut), .aborted(aborted),
    .l1aCount(l1aCount), .errCount(errCount), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (genReset_n !== 1'b0 || disTrig !== 1'b1) begin bad++; $display("FAIL reset_chain got genReset_n=%0b disTrig=%0b want 0/1", genReset_n, disTrig); end
    total++; if ({busy, done, timedOut, aborted} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, timedOut, aborted}); end
    total++; if (l1aCount !== 16'd0 || errCount !== 16'd0 || dataRate !== 2'd0 || trigInterval !== 8'd0) begin bad++; $display("FAIL reset_regs got l1a=%0d err=%0d rate=%0d intv=%0h want zeros", l1aCount, errCount, dataRate, trigInterval); end
    reset = 1'b1;
    tick();
    total++; if (state !== 3'd0 || genReset_n !== 1'b0) begin bad++; $display("FAIL idle_hold got state=%0d genReset_n=%0b want 0/0", state, genReset_n); end
  endtask

  task automatic test_normal;
    int n;
    runLengthCfg = 16'd5;
    dataRateCfg = 2'd2;
    trigIntervalCfg = 8'hA5;
    pulse_start();
    total++; if (state !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL norm_enter_reset got state=%0d busy=%0b want 1/1", state, busy); end
    total++; if (dataRate !== 2'd2 || trigInterval !== 8'hA5) begin bad++; $display("FAIL norm_latch got rate=%0d intv=%0h want 2/a5", dataRate, trigInterval); end
    runLengthCfg = 16'd99;
    dataRateCfg = 2'd0;
    n = 0;
    while (genReset_n === 1'b0 && n < 100) begin n++; tick(); end
    total++; if (n !== 16) begin bad++; $display("FAIL norm_reset_len got=%0d want=16", n); end
    total++; if (state !== 3'd2) begin bad++; $display("FAIL norm_settle_state got=%0d want=2", state); end
    n = 0;
    while (disTrig === 1'b1 && n < 200) begin n++; tick(); end
    total++; if (n !== 64) begin bad++; $display("FAIL norm_settle_len got=%0d want=64", n); end
    total++; if (state !== 3'd3 || dataRate !== 2'd2) begin bad++; $display("FAIL norm_run got state=%0d rate=%0d want 3/2", state, dataRate); end
    L1A = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) begin
        total++; if (disTrig !== 1'b0 || l1aCount !== 16'd4) begin bad++; $display("FAIL norm_4th got disTrig=%0b l1a=%0d want 0/4", disTrig, l1aCount); end
      end
    end
    L1A = 1'b0;
    total++; if (state !== 3'd4 || disTrig !== 1'b1 || l1aCount !== 16'd5) begin bad++; $display("FAIL norm_5th got state=%0d disTrig=%0b l1a=%0d want 4/1/5", state, disTrig, l1aCount); end
    n = 0;
    while (state === 3'd4 && n < 200) begin n++; tick(); end
    total++; if (n !== 32) begin bad++; $display("FAIL norm_drain_len got=%0d want=32", n); end
    total++; if (state !== 3'd5 || done !== 1'b1 || timedOut !== 1'b0 || busy !== 1'b0 || genReset_n !== 1'b1) begin bad++; $display("FAIL norm_done got state=%0d done=%0b to=%0b busy=%0b grn=%0b want 5/1/0/0/1", state, done, timedOut, busy, genReset_n); end
  endtask

  task automatic test_drain_timeout;
    int n;
    runLengthCfg = 16'd1;
    streamBufAlmostFull = 1'b1;
    pulse_start();
    total++; if (l1aCount !== 16'd0 || done !== 1'b0) begin bad++; $display("FAIL to_restart got l1a=%0d done=%0b want 0/0", l1aCount, done); end
    n = 0;
    while (state !== 3'd3 && n < 200) begin n++; tick(); end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL to_reach_run got state=%0d want=3", state); end
    L1A = 1'b1;
    tick();
    L1A = 1'b0;
    n = 0;
    while (state === 3'd4 && n < 5000) begin n++; tick(); end
    total++; if (n !== 4096) begin bad++; $display("FAIL to_drain_len got=%0d want=4096", n); end
    total++; if (done !== 1'b1 || timedOut !== 1'b1 || l1aCount !== 16'd1) begin bad++; $display("FAIL to_status got done=%0b to=%0b l1a=%0d want 1/1/1", done, timedOut, l1aCount); end
    streamBufAlmostFull = 1'b0;
  endtask

  task automatic test_abort_settle;
    int n;
    logic saw_low;
    saw_low = 1'b0;
    runLengthCfg = 16'd5;
    pulse_start();
    total++; if (timedOut !== 1'b0) begin bad++; $display("FAIL ab_flag_clear got=%0b want=0", timedOut); end
    n = 0;
    while (state !== 3'd2 && n < 50) begin n++; tick(); end
    for (int i = 0; i < 9; i++) begin tick(); if (disTrig !== 1'b1) saw_low = 1'b1; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (state !== 3'd4 || aborted !== 1'b1 || disTrig !== 1'b1) begin bad++; $display("FAIL ab_to_drain got state=%0d ab=%0b disTrig=%0b want 4/1/1", state, aborted, disTrig); end
    n = 0;
    while (state !== 3'd5 && n < 100) begin
      n++;
      if (disTrig !== 1'b1) saw_low = 1'b1;
      tick();
    end
    total++; if (done !== 1'b1 || l1aCount !== 16'd0 || aborted !== 1'b1) begin bad++; $display("FAIL ab_done got done=%0b l1a=%0d ab=%0b want 1/0/1", done, l1aCount, aborted); end
    total++; if (saw_low !== 1'b0) begin bad++; $display("FAIL ab_distrig_low got=%0b want=0", saw_low); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (state !== 3'd5) begin bad++; $display("FAIL ab_in_done got state=%0d want=5", state); end
  endtask

  task automatic test_free_run;
    int n;
    runLengthCfg = 16'd0;
    dataRateCfg = 2'd1;
    trigIntervalCfg = 8'h33;
    pulse_start();
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL fr_ab_clear got=%0b want=0", aborted); end
    n = 0;
    while (state !== 3'd3 && n < 200) begin n++; tick(); end
    for (int i = 0; i < 3; i++) begin L1A = 1'b1; tick(); L1A = 1'b0; tick(); end
    noError = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    noError = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    total++; if (state !== 3'd3 || l1aCount !== 16'd3 || errCount !== 16'd7) begin bad++; $display("FAIL fr_running got state=%0d l1a=%0d err=%0d want 3/3/7", state, l1aCount, errCount); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (state !== 3'd4 || aborted !== 1'b1) begin bad++; $display("FAIL fr_abort got state=%0d ab=%0b want 4/1", state, aborted); end
    n = 0;
    while (state !== 3'd5 && n < 100) begin n++; tick(); end
    total++; if (done !== 1'b1 || errCount !== 16'd7) begin bad++; $display("FAIL fr_done got done=%0b err=%0d want 1/7", done, errCount); end
    pulse_start();
    total++; if (state !== 3'd1 || errCount !== 16'd0 || l1aCount !== 16'd0 || aborted !== 1'b0) begin bad++; $display("FAIL fr_restart got state=%0d err=%0d l1a=%0d ab=%0b want 1/0/0/0", state, errCount, l1aCount, aborted); end
  endtask

  task automatic test_async_reset;
    int n;
    n = 0;
    while (state !== 3'd3 && n < 200) begin n++; tick(); end
    total++; if (state !== 3'd3 || genReset_n !== 1'b1) begin bad++; $display("FAIL ar_reach_run got state=%0d grn=%0b want 3/1", state, genReset_n); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (state !== 3'd0 || genReset_n !== 1'b0 || disTrig !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ar_immediate got state=%0d grn=%0b dt=%0b busy=%0b want 0/0/1/0", state, genReset_n, disTrig, busy); end
    total++; if (dataRate !== 2'd0 || trigInterval !== 8'd0) begin bad++; $display("FAIL ar_cfg got rate=%0d intv=%0h want 0/0", dataRate, trigInterval); end
    tick();
    reset = 1'b1;
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL ar_after got state=%0d want=0", state); end
  endtask

  task automatic test_start_abort_idle;
    dataRateCfg = 2'd3;
    trigIntervalCfg = 8'h5A;
    runLengthCfg = 16'd4;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++; if (state !== 3'd0 || genReset_n !== 1'b0) begin bad++; $display("FAIL sa_idle got state=%0d grn=%0b want 0/0", state, genReset_n); end
    total++; if (dataRate !== 2'd0 || trigInterval !== 8'd0) begin bad++; $display("FAIL sa_nolatch got rate=%0d intv=%0h want 0/0", dataRate, trigInterval); end
    for (int i = 0; i < 3; i++) tick();
    total++; if (state !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL sa_stays got state=%0d busy=%0b want 0/0", state, busy); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_drain_timeout();
    test_abort_settle();
    test_free_run();
    test_async_reset();
    test_start_abort_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
